saturn_bus_sequencer: RTL
=========================

SATURN_BUS_SEQUENCER -- requirements
Module: saturn_bus_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, bus nibble width.
REQ-002 SHALL have parameter PROG_DEPTH, default 32, program FIFO depth (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 5, read-burst counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- i_clk  in  1  sole clock, rising edge
- i_reset  in  1  synchronous active-high reset
REQ-005 SHALL have these remaining ports:
- i_clk_en  in  1  global clock enable
- i_hold  in  1  stall (ALU busy or debug cycle); freezes phase actions
- i_phases  in  4  one-hot bus phase (0001..1000)
- i_prog_valid  in  1  program entry offered
- i_prog_is_cmd  in  1  entry is command (1) or data (0)
- i_prog_data  in  DATA_W  entry nibble
- o_prog_ready  out  1  FIFO not full
- i_read_req  in  1  read-burst request
- i_read_count  in  CNT_W  nibbles to read
- o_bus_clk_en  out  1  bus strobe
- o_bus_is_data  out  1  current bus transfer is data
- o_bus_nibble_out  out  DATA_W  nibble driven to bus
- i_bus_nibble_in  in  DATA_W  nibble read from bus
- o_read_valid  out  1  one-clock pulse, o_read_data valid
- o_read_data  out  DATA_W  captured nibble
- o_busy  out  1  sequence in progress
- o_error  out  1  sticky protocol error
- o_level  out  $clog2(PROG_DEPTH)+1  FIFO occupancy

Function
REQ-006 Push SHALL occur on any clock with i_clk_en && i_prog_valid && o_prog_ready; o_prog_ready = (o_level != PROG_DEPTH).
REQ-007 Push while full SHALL be dropped and SHALL set o_error; no push-through, even when a pop occurs on the same clock.
REQ-008 Step SHALL mean i_clk_en && !i_hold && i_phases one-hot; a non-one-hot i_phases SHALL cause no action.
REQ-009 Phase 0001 with FIFO non-empty: pop head, o_bus_nibble_out<=data, o_bus_is_data<=!is_cmd, o_bus_clk_en<=1, state SEND.
REQ-010 Phase 0001 with FIFO empty and read_remaining>0: o_bus_is_data<=1, o_bus_clk_en<=1, state READ; writes SHALL always take priority over reads.
REQ-011 Phase 0001 with nothing pending: state IDLE, bus outputs unchanged.
REQ-012 Phase 0010: o_bus_clk_en<=0; if state READ, o_read_data<=i_bus_nibble_in, o_read_valid=1 for exactly one clock, read_remaining decremented.
REQ-013 Phase 0100: if FIFO empty, read_remaining==0 and no push this clock, o_busy<=0, state IDLE.
REQ-014 Phase 1000: no action.
REQ-015 Push or accepted read request SHALL set o_busy on the next clock.
REQ-016 i_read_req with read_remaining==0 SHALL load i_read_count (count 0 is a no-op); with read_remaining!=0 it SHALL be ignored and set o_error.
REQ-017 FIFO pointers SHALL wrap modulo PROG_DEPTH; o_level SHALL be exact for simultaneous push and pop.
REQ-018 While i_hold=1, all registers except FIFO push path SHALL hold value.
REQ-019 o_error SHALL clear only on reset.

Reset
REQ-020 Reset SHALL set: FIFO empty, o_level=0, read_remaining=0, state IDLE, o_bus_clk_en=0, o_bus_is_data=0, o_bus_nibble_out=0, o_read_valid=0, o_read_data=0, o_error=0, o_busy=1.
REQ-021 Reset SHALL win over every simultaneous event, flushing an in-progress sequence mid-phase.

Structure
REQ-022 Package saturn_bus_pkg SHALL hold phase one-hot constants, state enum (IDLE, SEND, READ) and the program-entry typedef {is_cmd, data}.
REQ-023 The FIFO SHALL be sub-module saturn_bus_prog_fifo (depth/width parametrised, level output).

Verification
REQ-024 Push CMD 4, DATA 2, DATA 0 then run phases -> three strobes in consecutive 0001 phases, is_data 0,1,1, nibbles 4,2,0; o_busy drops at third 0100.
REQ-025 Fill 32 entries with PROG_DEPTH=32 -> o_prog_ready=0, o_level=32; 33rd push dropped, o_error=1.
REQ-026 Read count 3, bus returns A,B,C -> three o_read_valid pulses in phase 0010 with A,B,C, then o_busy=0.
REQ-027 Push CMD 3 and read count 2 together -> command sent first, then two reads.
REQ-028 Hold asserted across 0001 -> no strobe; after release, next 0001 issues the entry.
REQ-029 Reset mid-burst (remaining 2) -> all outputs at reset values next clock, no further o_read_valid.

Source files
------------

// File: rtl/saturn_bus_pkg.sv
// Shared types and constants for the Saturn nibble-bus sequencer.
// Phase encodings, sequencer states and the program-entry layout.
package saturn_bus_pkg;

    localparam logic [3:0] PH_1 = 4'b0001;
    localparam logic [3:0] PH_2 = 4'b0010;
    localparam logic [3:0] PH_3 = 4'b0100;
    localparam logic [3:0] PH_4 = 4'b1000;

    // Widest nibble the entry type can carry; narrower buses zero-extend.
    localparam int MAX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        READ
    } seq_state_t;

    typedef struct packed {
        logic                  is_cmd;
        logic [MAX_DATA_W-1:0] data;
    } prog_entry_t;

    function automatic logic is_onehot4(input logic [3:0] p);
        return (p != 4'b0) && ((p & (p - 4'd1)) == 4'b0);
    endfunction

endpackage

// File: rtl/saturn_bus_sequencer_if.sv
// Host/bus side signal bundle of the Saturn bus sequencer.
// master = sequencer side, slave = host/bus side.
interface saturn_bus_sequencer_if #(
    parameter int DATA_W     = 4,
    parameter int CNT_W      = 5,
    parameter int PROG_DEPTH = 32
);
    localparam int LVL_W = $clog2(PROG_DEPTH) + 1;

    logic              i_clk_en;
    logic              i_hold;
    logic [3:0]        i_phases;
    logic              i_prog_valid;
    logic              i_prog_is_cmd;
    logic [DATA_W-1:0] i_prog_data;
    logic              o_prog_ready;
    logic              i_read_req;
    logic [CNT_W-1:0]  i_read_count;
    logic              o_bus_clk_en;
    logic              o_bus_is_data;
    logic [DATA_W-1:0] o_bus_nibble_out;
    logic [DATA_W-1:0] i_bus_nibble_in;
    logic              o_read_valid;
    logic [DATA_W-1:0] o_read_data;
    logic              o_busy;
    logic              o_error;
    logic [LVL_W-1:0]  o_level;

    modport master (
        input  i_clk_en, i_hold, i_phases,
        input  i_prog_valid, i_prog_is_cmd,
        input  i_prog_data,
        output o_prog_ready,
        input  i_read_req, i_read_count,
        output o_bus_clk_en, o_bus_is_data,
        output o_bus_nibble_out,
        input  i_bus_nibble_in,
        output o_read_valid, o_read_data,
        output o_busy, o_error, o_level
    );

    modport slave (
        output i_clk_en, i_hold, i_phases,
        output i_prog_valid, i_prog_is_cmd,
        output i_prog_data,
        input  o_prog_ready,
        output i_read_req, i_read_count,
        input  o_bus_clk_en, o_bus_is_data,
        input  o_bus_nibble_out,
        output i_bus_nibble_in,
        input  o_read_valid, o_read_data,
        input  o_busy, o_error, o_level
    );

endinterface

// File: rtl/saturn_bus_prog_fifo.sv
// Program FIFO for the bus sequencer: power-of-two depth,
// wrapping pointers and an exact occupancy count.
module saturn_bus_prog_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 5,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_level   = r_level;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/saturn_bus_sequencer.sv
// Saturn nibble-bus sequencer: drains a program FIFO onto the bus
// in phase 0001 and runs read bursts when no writes are pending.
module saturn_bus_sequencer
    import saturn_bus_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PROG_DEPTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic i_clk,
    input  logic i_reset,
    saturn_bus_sequencer_if.master io
);

    localparam int LW = $clog2(PROG_DEPTH) + 1;

    logic              w_push;
    logic              w_drop;
    logic              w_step;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_rem_zero;
    logic              w_rd_acc;
    logic              w_rd_rej;
    logic [LW-1:0]     w_level;
    logic [DATA_W:0]   w_wr_raw;
    logic [DATA_W:0]   w_hd_raw;
    prog_entry_t       w_wr_ent;
    prog_entry_t       w_hd_ent;

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_rem;
    logic              r_bus_clk_en;
    logic              r_bus_is_data;
    logic [DATA_W-1:0] r_nibble;
    logic              r_read_valid;
    logic [DATA_W-1:0] r_read_data;
    logic              r_error;
    logic              r_busy;

    // Pushes ignore i_hold; everything else waits for a step.
    assign w_push = io.i_clk_en && io.i_prog_valid && !w_full;
    assign w_drop = io.i_clk_en && io.i_prog_valid && w_full;
    assign w_step = io.i_clk_en && !io.i_hold
                 && is_onehot4(io.i_phases);
    assign w_pop  = w_step && (io.i_phases == PH_1) && !w_empty;

    assign w_rem_zero = (r_rem == '0);
    assign w_rd_acc = io.i_clk_en && !io.i_hold && io.i_read_req
                   && w_rem_zero && (io.i_read_count != '0);
    assign w_rd_rej = io.i_clk_en && !io.i_hold && io.i_read_req
                   && !w_rem_zero;

    always_comb begin
        w_wr_ent        = '0;
        w_wr_ent.is_cmd = io.i_prog_is_cmd;
        w_wr_ent.data   = MAX_DATA_W'(io.i_prog_data);
        w_wr_raw        = {w_wr_ent.is_cmd, DATA_W'(w_wr_ent.data)};
        w_hd_ent        = '0;
        w_hd_ent.is_cmd = w_hd_raw[DATA_W];
        w_hd_ent.data   = MAX_DATA_W'(w_hd_raw[DATA_W-1:0]);
    end

    saturn_bus_prog_fifo #(
        .DEPTH (PROG_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata (w_wr_raw),
        .i_pop   (w_pop),
        .o_rdata (w_hd_raw),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_rem         <= '0;
            r_bus_clk_en  <= 1'b0;
            r_bus_is_data <= 1'b0;
            r_nibble      <= '0;
            r_read_valid  <= 1'b0;
            r_read_data   <= '0;
            r_error       <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_read_valid <= 1'b0;
            if (w_step) begin
                unique case (io.i_phases)
                    PH_1: begin
                        if (!w_empty) begin
                            r_nibble      <= DATA_W'(w_hd_ent.data);
                            r_bus_is_data <= !w_hd_ent.is_cmd;
                            r_bus_clk_en  <= 1'b1;
                            r_state       <= SEND;
                        end else if (!w_rem_zero) begin
                            r_bus_is_data <= 1'b1;
                            r_bus_clk_en  <= 1'b1;
                            r_state       <= READ;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    PH_2: begin
                        r_bus_clk_en <= 1'b0;
                        if (r_state == READ && !w_rem_zero) begin
                            r_read_data  <= io.i_bus_nibble_in;
                            r_read_valid <= 1'b1;
                            r_rem        <= r_rem - CNT_W'(1);
                        end
                    end
                    PH_3: begin
                        if (w_empty && w_rem_zero && !w_push) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    PH_4: ;
                    default: ;
                endcase
            end
            if (w_rd_acc) begin
                r_rem <= io.i_read_count;
            end
            if (w_drop || w_rd_rej) begin
                r_error <= 1'b1;
            end
            // New work re-arms busy even if this clock's 0100 cleared it.
            if (w_push || w_rd_acc) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign io.o_prog_ready     = !w_full;
    assign io.o_level          = w_level;
    assign io.o_bus_clk_en     = r_bus_clk_en;
    assign io.o_bus_is_data    = r_bus_is_data;
    assign io.o_bus_nibble_out = r_nibble;
    assign io.o_read_valid     = r_read_valid;
    assign io.o_read_data      = r_read_data;
    assign io.o_busy           = r_busy;
    assign io.o_error          = r_error;

endmodule
